fetch_stage_ctrl: RTL and testbench

FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

---
 rtl/fetch_stage_ctrl.sv | 145 ++++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_stage_ctrl
//
// Purpose:
//   Instruction-fetch stage control. It owns the program counter and the IF/ID
//   pipeline register, and it registers the ID/EX bubble request. Every output
//   comes straight from a flop, so no input reaches an output combinationally.
//   Each control takes effect at the next rising edge of clk.
//
// Configuration:
//   PERF_CNT_EN - when this macro is defined, the block adds the stall_cnt and
//                 flush_cnt performance counters and their ports. When it is
//                 undefined, the counters and their ports do not exist.
//
// Ports:
//   clk            in   1   single clock; all state changes on the rising edge
//   reset          in   1   synchronous, active-high; overrides every input
//   pckeep         in   1   hold pc this cycle (load-use stall)
//   control_if_id  in   2   IF/ID command: 00 go, 01 flush, 10 keep, 11 flush
//   flush_id_ex    in   1   load a bubble into ID/EX at the next edge
//   dobranch       in   1   taken branch resolved in ID (wins over dojump)
//   dojump         in   1   j/jal/jr resolved in ID
//   branch_target  in  32   branch destination; bits [1:0] are ignored
//   jump_target    in  32   jump destination; bits [1:0] are ignored
//   imem_instr     in  32   instruction read combinationally at pc
//   pc             out 32   current fetch address
//   if_id_instr    out 32   IF/ID instruction (0 = nop after a flush)
//   if_id_pc4      out 32   IF/ID pc+4
//   if_id_valid    out  1   IF/ID holds a real instruction
//   id_ex_bubble   out  1   ID/EX was loaded with a bubble at the last edge
//   stall_cnt      out 32   edges with pckeep=1           (PERF_CNT_EN only)
//   flush_cnt      out 32   edges with an IF/ID flush     (PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_stage_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        pckeep,
    input  logic [1:0]  control_if_id,
    input  logic        flush_id_ex,
    input  logic        dobranch,
    input  logic        dojump,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        id_ex_bubble
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    // IF/ID command encoding. RSVD is decoded as a flush so that an illegal
    // command can never let a stale instruction through.
    typedef enum logic [1:0] {
        IFID_GO    = 2'b00,
        IFID_FLUSH = 2'b01,
        IFID_KEEP  = 2'b10,
        IFID_RSVD  = 2'b11
    } if_id_cmd_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_NOP = '{instr: 32'h0, pc4: 32'h0, valid: 1'b0};

    if_id_cmd_e  if_id_cmd;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    if_id_t      if_id_q;
    if_id_t      if_id_next;

    assign if_id_cmd = if_id_cmd_e'(control_if_id);

    // The addition wraps naturally, so 32'hFFFFFFFC + 4 gives 0.
    assign pc_plus4 = pc + 32'd4;

    // Next-pc priority order: stall, then branch, then jump, then sequential.
    // Placing branch ahead of jump settles the case where both are high.
    always_comb begin
        pc_next = pc_plus4;
        if (pckeep)
            pc_next = pc;
        else if (dobranch)
            pc_next = {branch_target[31:2], 2'b00};
        else if (dojump)
            pc_next = {jump_target[31:2], 2'b00};
    end

    // The IF/ID update depends only on control_if_id. A stall on pc does not
    // freeze this register by itself, so a stall combined with a flush still
    // flushes IF/ID.
    always_comb begin
        if_id_next = if_id_q;
        unique case (if_id_cmd)
            IFID_GO:    if_id_next = '{instr: imem_instr, pc4: pc_plus4, valid: 1'b1};
            IFID_KEEP:  if_id_next = if_id_q;
            IFID_FLUSH,
            IFID_RSVD:  if_id_next = IF_ID_NOP;
            default:    if_id_next = IF_ID_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= 32'h0;
            if_id_q      <= IF_ID_NOP;
            id_ex_bubble <= 1'b0;
        end else begin
            pc           <= pc_next;
            if_id_q      <= if_id_next;
            id_ex_bubble <= flush_id_ex;
        end
    end

    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;

`ifdef PERF_CNT_EN
    // Both counters wrap at 2^32 and are not saturated.
    logic if_id_flush;
    assign if_id_flush = (if_id_cmd == IFID_FLUSH) || (if_id_cmd == IFID_RSVD);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else begin
            if (pckeep)
                stall_cnt <= stall_cnt + 32'd1;
            if (if_id_flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage_ctrl
//
// Self-checking bench for fetch_stage_ctrl. The bench keeps its own reference
// model of the architectural state and compares the DUT outputs to it on every
// falling edge. A directed sequence checks literal expected values, and a
// randomized phase follows it.
// -----------------------------------------------------------------------------
module tb_fetch_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        pckeep;
    logic [1:0]  control_if_id;
    logic        flush_id_ex;
    logic        dobranch;
    logic        dojump;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        id_ex_bubble;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .pckeep        (pckeep),
        .control_if_id (control_if_id),
        .flush_id_ex   (flush_id_ex),
        .dobranch      (dobranch),
        .dojump        (dojump),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem_instr    (imem_instr),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .id_ex_bubble  (id_ex_bubble)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference model. It holds the architectural state that the DUT should
    // show after each edge.
    logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
    logic        m_valid, m_bub;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic [31:0] npc;
        if (reset) begin
            m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_bub = 1'b0;
            m_stall = '0; m_flush = '0;
        end else begin
            if (pckeep)        npc = m_pc;
            else if (dobranch) npc = branch_target & 32'hFFFF_FFFC;
            else if (dojump)   npc = jump_target & 32'hFFFF_FFFC;
            else               npc = m_pc + 32'd4;
            if (control_if_id == 2'b00) begin
                m_instr = imem_instr; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end else if (control_if_id != 2'b10) begin
                m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
                m_flush = m_flush + 32'd1;
            end
            if (pckeep) m_stall = m_stall + 32'd1;
            m_bub = flush_id_ex;
            m_pc  = npc;
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("if_id_instr", if_id_instr, m_instr);
            check("if_id_pc4", if_id_pc4, m_pc4);
            check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            check("id_ex_bubble", {31'b0, id_ex_bubble}, {31'b0, m_bub});
`ifdef PERF_CNT_EN
            check("stall_cnt", stall_cnt, m_stall);
            check("flush_cnt", flush_cnt, m_flush);
`endif
        end
    end

    // Applies one rising edge and then settles just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; pckeep = 1'b0; control_if_id = 2'b00; flush_id_ex = 1'b0;
        dobranch = 1'b0; dojump = 1'b0; branch_target = '0; jump_target = '0;
    endtask

    initial begin
        idle();
        imem_instr = 32'hDEAD_BEEF;
        reset = 1'b1;
        pckeep = 1'b1; control_if_id = 2'b00; flush_id_ex = 1'b1;
        cyc(); cyc();
        idle();
        check("rst pc", pc, 32'h0);
        check("rst instr", if_id_instr, 32'h0);
        check("rst pc4", if_id_pc4, 32'h0);
        check("rst valid", {31'b0, if_id_valid}, 32'h0);
        check("rst bubble", {31'b0, id_ex_bubble}, 32'h0);
        chk_en = 1'b1;

        // Sequential fetch: A at pc 0, then B at pc 4.
        imem_instr = 32'hAAAA_0001; cyc();
        check("seq pc4", pc, 32'h4);
        check("seq instrA", if_id_instr, 32'hAAAA_0001);
        check("seq pc4A", if_id_pc4, 32'h4);
        check("seq validA", {31'b0, if_id_valid}, 32'h1);
        imem_instr = 32'hBBBB_0002; cyc();
        check("seq pc8", pc, 32'h8);
        check("seq instrB", if_id_instr, 32'hBBBB_0002);
        check("seq pc4B", if_id_pc4, 32'h8);

        // Stall at pc=8 while keeping IF/ID.
        pckeep = 1'b1; control_if_id = 2'b10; imem_instr = 32'h1111_1111; cyc();
        check("stall pc", pc, 32'h8);
        check("stall instr", if_id_instr, 32'hBBBB_0002);
        check("stall pc4", if_id_pc4, 32'h8);
`ifdef PERF_CNT_EN
        check("stall cnt", stall_cnt, 32'h1);
`endif
        idle();
        imem_instr = 32'hCCCC_0003; cyc();
        check("seq pc12", pc, 32'hC);
        check("seq instrC", if_id_instr, 32'hCCCC_0003);
        check("seq pc4C", if_id_pc4, 32'hC);
        imem_instr = 32'hDDDD_0004; cyc();
        check("seq pc16", pc, 32'h10);

        // Taken branch at pc=16 with an IF/ID flush and an ID/EX bubble.
        dobranch = 1'b1; branch_target = 32'h0000_0103; control_if_id = 2'b01;
        flush_id_ex = 1'b1; cyc();
        check("br pc", pc, 32'h100);
        check("br valid", {31'b0, if_id_valid}, 32'h0);
        check("br instr", if_id_instr, 32'h0);
        check("br bubble1", {31'b0, id_ex_bubble}, 32'h1);
        idle(); cyc();
        check("br bubble0", {31'b0, id_ex_bubble}, 32'h0);
        check("br pc+4", pc, 32'h104);

        // Branch beats jump when both are high.
        dobranch = 1'b1; dojump = 1'b1; jump_target = 32'h200; branch_target = 32'h300; cyc();
        check("br>jmp pc", pc, 32'h300);

        // pc wraps from the top of the address space.
        idle(); dojump = 1'b1; jump_target = 32'hFFFF_FFFF; cyc();
        check("jmp top", pc, 32'hFFFF_FFFC);
        idle(); cyc();
        check("wrap pc", pc, 32'h0);
        check("wrap pc4", if_id_pc4, 32'h0);

        // Reset during a stall combined with a flush.
        pckeep = 1'b1; control_if_id = 2'b01; reset = 1'b1; cyc();
        check("rst2 pc", pc, 32'h0);
        check("rst2 valid", {31'b0, if_id_valid}, 32'h0);
        check("rst2 pc4", if_id_pc4, 32'h0);
`ifdef PERF_CNT_EN
        check("rst2 stall", stall_cnt, 32'h0);
`endif

        // The reserved command behaves as a flush.
        idle(); imem_instr = 32'h5555_AAAA; cyc();
        check("pre11 valid", {31'b0, if_id_valid}, 32'h1);
        control_if_id = 2'b11; cyc();
        check("c11 valid", {31'b0, if_id_valid}, 32'h0);
        check("c11 instr", if_id_instr, 32'h0);
        check("c11 pc4", if_id_pc4, 32'h0);
`ifdef PERF_CNT_EN
        check("c11 flush", flush_cnt, 32'h1);
`endif

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            pckeep        = ($urandom_range(0, 3) == 0);
            control_if_id = 2'($urandom_range(0, 3));
            flush_id_ex   = 1'($urandom_range(0, 1));
            dobranch      = ($urandom_range(0, 5) == 0);
            dojump        = ($urandom_range(0, 5) == 0);
            branch_target = $urandom;
            jump_target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            imem_instr    = $urandom;
            cyc();
        end

        idle(); cyc();
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
